// File: rtl/dev_bridge.sv
// dev_bridge: CPU-side initiator for the word-addressed device bus.
// Decodes CPU load/store addresses into fixed 16-byte device windows, drives
// the shared ADD/DAT/WE lines, returns load data over a req/ack handshake and
// registers the device IRQ lines into the HWInt vector.
//
// Every bus- and CPU-facing output is a flop fed from the current state. As a
// result, each state's effect shows up one cycle after that state is entered:
//   edge N   : IDLE samples PrReq, latches the request        -> ACCESS
//   edge N+1 : DEV_WE pulses (store hit)                      -> ACK
//   edge N+2 : PrAck/PrErr pulse, PrRD updated (load)          -> IDLE
// IDLE can accept again at edge N+3, so back-to-back acks are 3 cycles apart.
module dev_bridge #(
  parameter int          N_DEV     = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic                   CLK_I,
  input  logic                   RST_N_I,
  input  logic                   PrReq,
  input  logic                   PrWE,
  input  logic [31:0]            PrAddr,
  input  logic [31:0]            PrWD,
  output logic [31:0]            PrRD,
  output logic                   PrAck,
  output logic                   PrErr,
  output logic [1:0]             DEV_ADD,
  output logic [31:0]            DEV_DAT,
  output logic [N_DEV-1:0]       DEV_WE,
  input  logic [32*N_DEV-1:0]    DEV_RD,
  input  logic [N_DEV-1:0]       DEV_IRQ,
  output logic [5:0]             HWInt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state, state_nxt;

  // latched request attributes, valid from ACCESS through ACK
  logic       we_q;
  logic       hit_q;
  logic [2:0] slot_q;

  // address decode of the live CPU request
  logic [31:0] off;
  logic        hit;
  logic [2:0]  slot;
  logic        accept;
  logic        unused_bits;

  logic [N_DEV-1:0] we_nxt;
  logic [31:0]      rd_sel;

  // An address below BASE_ADDR wraps to a huge offset, so the range test on
  // off[31:4] alone would already reject it; the explicit >= keeps intent clear.
  assign off    = PrAddr - BASE_ADDR;
  assign hit    = (PrAddr >= BASE_ADDR) && (off[31:4] < 28'(N_DEV));
  assign slot   = off[6:4];
  assign accept = (state == IDLE) && PrReq;

  // byte lane bits are ignored; the in-window word select comes from PrAddr[3:2]
  assign unused_bits = ^{off[3:0], PrAddr[1:0]};

  // state register
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state and the one-hot write strobe for the access cycle
  always_comb begin
    state_nxt = state;
    we_nxt    = '0;
    case (state)
      IDLE:   if (PrReq) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = ACK;
        if (we_q && hit_q) begin
          for (int k = 0; k < N_DEV; k++) begin
            if (slot_q == 3'(k)) we_nxt[k] = 1'b1;
          end
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // read-data mux over the device slots, driven by the latched slot
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (slot_q == 3'(k)) rd_sel = DEV_RD[32*k +: 32];
    end
  end

  // request latch: DEV_ADD/DEV_DAT hold until the next accepted request
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      slot_q  <= '0;
      DEV_ADD <= '0;
      DEV_DAT <= '0;
    end else if (accept) begin
      we_q    <= PrWE;
      hit_q   <= hit;
      slot_q  <= hit ? slot : 3'd0;
      DEV_ADD <= PrAddr[3:2];
      DEV_DAT <= PrWD;
    end
  end

  // bus write strobe, single cycle per store hit
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) DEV_WE <= '0;
    else          DEV_WE <= we_nxt;
  end

  // CPU completion: ack/err pulse, load data capture (zero on a miss)
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      PrAck <= 1'b0;
      PrErr <= 1'b0;
      PrRD  <= '0;
    end else begin
      PrAck <= (state == ACK);
      PrErr <= (state == ACK) && !hit_q;
      if ((state == ACK) && !we_q) PrRD <= hit_q ? rd_sel : 32'd0;
    end
  end

  // interrupt sampling, free-running and unlatched
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) HWInt <= '0;
    else          HWInt <= 6'(DEV_IRQ);
  end

endmodule

// File: tb/tb_dev_bridge.sv
// tb_dev_bridge: directed-vector bench for dev_bridge (N_DEV=3, base 0x7F00).
module tb_dev_bridge;

  localparam int N_DEV = 3;

  logic                CLK_I;
  logic                RST_N_I;
  logic                PrReq;
  logic                PrWE;
  logic [31:0]         PrAddr;
  logic [31:0]         PrWD;
  logic [31:0]         PrRD;
  logic                PrAck;
  logic                PrErr;
  logic [1:0]          DEV_ADD;
  logic [31:0]         DEV_DAT;
  logic [N_DEV-1:0]    DEV_WE;
  logic [32*N_DEV-1:0] DEV_RD;
  logic [N_DEV-1:0]    DEV_IRQ;
  logic [5:0]          HWInt;

  int n_chk;
  int n_err;

  dev_bridge #(.N_DEV(N_DEV), .BASE_ADDR(32'h0000_7F00)) dut (
    .CLK_I   (CLK_I),
    .RST_N_I (RST_N_I),
    .PrReq   (PrReq),
    .PrWE    (PrWE),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrRD    (PrRD),
    .PrAck   (PrAck),
    .PrErr   (PrErr),
    .DEV_ADD (DEV_ADD),
    .DEV_DAT (DEV_DAT),
    .DEV_WE  (DEV_WE),
    .DEV_RD  (DEV_RD),
    .DEV_IRQ (DEV_IRQ),
    .HWInt   (HWInt)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // one isolated transaction; expectations are passed in by the caller
  task automatic txn(input string tag, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [1:0] exp_add,
                     input logic [2:0] exp_we, input bit exp_err,
                     input logic [31:0] exp_rd);
    PrReq = 1'b1; PrWE = we; PrAddr = addr; PrWD = wd;
    tick();                                   // edge N: accepted
    chk({tag, " add"},  {30'd0, DEV_ADD}, {30'd0, exp_add});
    chk({tag, " dat"},  DEV_DAT, wd);
    chk({tag, " we0"},  {29'd0, DEV_WE}, 32'd0);
    chk({tag, " ack0"}, {31'd0, PrAck}, 32'd0);
    tick();                                   // edge N+1: write strobe
    chk({tag, " we1"},  {29'd0, DEV_WE}, {29'd0, exp_we});
    chk({tag, " ack1"}, {31'd0, PrAck}, 32'd0);
    tick();                                   // edge N+2: ack
    chk({tag, " ack2"}, {31'd0, PrAck}, 32'd1);
    chk({tag, " err2"}, {31'd0, PrErr}, {31'd0, exp_err});
    chk({tag, " we2"},  {29'd0, DEV_WE}, 32'd0);
    chk({tag, " rd"},   PrRD, exp_rd);
    PrReq = 1'b0;
    tick();
    chk({tag, " ack3"}, {31'd0, PrAck}, 32'd0);
    chk({tag, " err3"}, {31'd0, PrErr}, 32'd0);
  endtask

  initial begin
    logic [5:0] ack_seen;
    n_chk = 0; n_err = 0;
    RST_N_I = 1'b0; PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    DEV_IRQ = '0;
    DEV_RD  = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

    // reset state
    repeat (2) tick();
    chk("rst ack",  {31'd0, PrAck}, 32'd0);
    chk("rst err",  {31'd0, PrErr}, 32'd0);
    chk("rst rd",   PrRD, 32'd0);
    chk("rst we",   {29'd0, DEV_WE}, 32'd0);
    chk("rst add",  {30'd0, DEV_ADD}, 32'd0);
    chk("rst dat",  DEV_DAT, 32'd0);
    chk("rst hw",   {26'd0, HWInt}, 32'd0);
    RST_N_I = 1'b1;
    tick();

    // stores to slot 0 word 1 and slot 2 word 2
    txn("st0", 1'b1, 32'h0000_7F04, 32'h0000_0005, 2'd1, 3'b001, 1'b0, 32'd0);
    txn("st2", 1'b1, 32'h0000_7F28, 32'h0000_00A5, 2'd2, 3'b100, 1'b0, 32'd0);
    // loads
    txn("ld2", 1'b0, 32'h0000_7F28, 32'h0000_0000, 2'd2, 3'b000, 1'b0, 32'hDEAD_BEEF);
    txn("ld1", 1'b0, 32'h0000_7F14, 32'h0000_0000, 2'd1, 3'b000, 1'b0, 32'h2222_2222);
    txn("ldtop", 1'b0, 32'h0000_7F2F, 32'h0, 2'd3, 3'b000, 1'b0, 32'hDEAD_BEEF);
    // misses: just past the last slot, and just below the base
    txn("ldmiss", 1'b0, 32'h0000_7F30, 32'h0, 2'd0, 3'b000, 1'b1, 32'd0);
    txn("ld0", 1'b0, 32'h0000_7F00, 32'h0, 2'd0, 3'b000, 1'b0, 32'h1111_1111);
    txn("stlow", 1'b1, 32'h0000_7EFC, 32'h77, 2'd3, 3'b000, 1'b1, 32'h1111_1111);
    txn("sthi",  1'b1, 32'h0000_7F30, 32'h88, 2'd0, 3'b000, 1'b1, 32'h1111_1111);
    txn("ldlow", 1'b0, 32'h0000_7EFC, 32'h0, 2'd3, 3'b000, 1'b1, 32'd0);

    // back-to-back loads with PrReq held high
    PrReq = 1'b1; PrWE = 1'b0; PrAddr = 32'h0000_7F18; PrWD = '0;
    ack_seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ack_seen[i] = PrAck;
      if (i == 5) PrReq = 1'b0;
    end
    chk("b2b pattern", {26'd0, ack_seen}, 32'b100100);
    chk("b2b rd", PrRD, 32'h2222_2222);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b quiet", {31'd0, PrAck}, 32'd0);
    end

    // IRQ registration
    DEV_IRQ = 3'b010;
    tick();
    chk("irq on", {26'd0, HWInt}, 32'b000010);
    DEV_IRQ = 3'b000;
    tick();
    chk("irq off", {26'd0, HWInt}, 32'd0);
    DEV_IRQ = 3'b111;
    tick();
    chk("irq all", {26'd0, HWInt}, 32'b000111);
    DEV_IRQ = 3'b000;
    tick();
    chk("irq clr", {26'd0, HWInt}, 32'd0);

    // reset during a store while the write strobe is up
    PrReq = 1'b1; PrWE = 1'b1; PrAddr = 32'h0000_7F24; PrWD = 32'h1234_5678;
    tick();
    tick();
    chk("rstmid we pre", {29'd0, DEV_WE}, 32'b100);
    #2 RST_N_I = 1'b0;
    #1;
    chk("rstmid we",  {29'd0, DEV_WE}, 32'd0);
    chk("rstmid ack", {31'd0, PrAck}, 32'd0);
    chk("rstmid dat", DEV_DAT, 32'd0);
    PrReq = 1'b0;
    tick();
    chk("rstmid hold ack", {31'd0, PrAck}, 32'd0);
    RST_N_I = 1'b1;
    tick();
    chk("post rst ack", {31'd0, PrAck}, 32'd0);
    chk("post rst add", {30'd0, DEV_ADD}, 32'd0);
    chk("post rst rd",  PrRD, 32'd0);
    txn("post ld", 1'b0, 32'h0000_7F28, 32'h0, 2'd2, 3'b000, 1'b0, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
